// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipeline front end.
package cpu_pkg;

  localparam int unsigned XLEN = 16;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [XLEN-1:0] addr_t;

  localparam word_t NO_OP = XLEN'(16'hF000);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // One fetched word together with the address it came from.
  typedef struct packed {
    word_t word;
    addr_t addr;
  } fetch_pkt_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage and imem.
interface if_fetch_unit_if;
  import cpu_pkg::*;

  logic  req;
  addr_t addr;
  word_t rdata;
  logic  ready;

  modport master (output req, output addr, input rdata, input ready);
  modport slave  (input req, input addr, output rdata, output ready);

endinterface

// File: rtl/if_skid_buf.sv
// Single-entry holding buffer for a word that completed while IF/ID was stalled.
module if_skid_buf
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clear,
  input  fetch_pkt_t din,
  output logic       valid,
  output fetch_pkt_t dout
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over imem req/ready, feeds IF/ID
// with real words or NO_OP bubbles, and handles branch/call/return redirects.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter addr_t RESET_PC = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hazard,
  input  logic                    redirect_valid,
  input  addr_t                   redirect_pc,
  if_fetch_unit_if.master         imem,
  output word_t                   instruction,
  output addr_t                   PC_out,
  output logic                    fetch_valid
);

  fetch_state_t state, state_d;
  addr_t        pc, pc_d;
  addr_t        tgt, tgt_d;
  word_t        instr_d;
  addr_t        pc_out_d;
  logic         fetch_valid_d;
  logic         buf_load, buf_clear, buf_valid;
  fetch_pkt_t   buf_q;
  logic         done;
  addr_t        pc_inc, buf_inc;

  // pc holds the outstanding address in DRAIN, so it doubles as the bus address.
  assign imem.req  = rst_n && (state != HOLD);
  assign imem.addr = pc;

  assign done    = imem.ready;
  assign pc_inc  = pc + addr_t'(1);
  assign buf_inc = buf_q.addr + addr_t'(1);

  if_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .clear (buf_clear),
    .din   ('{word: imem.rdata, addr: pc}),
    .valid (buf_valid),
    .dout  (buf_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      tgt         <= RESET_PC;
      instruction <= NO_OP;
      PC_out      <= RESET_PC;
      fetch_valid <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      tgt         <= tgt_d;
      instruction <= instr_d;
      PC_out      <= pc_out_d;
      fetch_valid <= fetch_valid_d;
    end
  end

  // Next state and next IF/ID outputs; redirect outranks hazard everywhere.
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    tgt_d         = tgt;
    instr_d       = instruction;
    pc_out_d      = PC_out;
    fetch_valid_d = fetch_valid;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;

    case (state)
      FETCH: begin
        if (done) begin
          if (redirect_valid) begin
            pc_d          = redirect_pc;
            instr_d       = NO_OP;
            fetch_valid_d = 1'b0;
          end else if (hazard) begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end else begin
            instr_d       = imem.rdata;
            pc_out_d      = pc_inc;
            fetch_valid_d = 1'b1;
            pc_d          = pc_inc;
          end
        end else if (redirect_valid) begin
          tgt_d         = redirect_pc;
          state_d       = DRAIN;
          instr_d       = NO_OP;
          fetch_valid_d = 1'b0;
        end else if (!hazard) begin
          instr_d       = NO_OP;
          fetch_valid_d = 1'b0;
        end
      end

      DRAIN: begin
        if (redirect_valid) tgt_d = redirect_pc;
        if (done) begin
          pc_d    = redirect_valid ? redirect_pc : tgt;
          state_d = FETCH;
        end
        if (redirect_valid || !hazard) begin
          instr_d       = NO_OP;
          fetch_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          buf_clear     = 1'b1;
          pc_d          = redirect_pc;
          instr_d       = NO_OP;
          fetch_valid_d = 1'b0;
          state_d       = FETCH;
        end else if (!hazard && buf_valid) begin
          buf_clear     = 1'b1;
          instr_d       = buf_q.word;
          pc_out_d      = buf_inc;
          fetch_valid_d = 1'b1;
          pc_d          = buf_inc;
          state_d       = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit against a memory returning 16'h1000 + addr.
module tb_if_fetch_unit;
  import cpu_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  hazard;
  logic  redirect_valid;
  addr_t redirect_pc;
  logic  mem_ready;
  word_t instruction;
  addr_t PC_out;
  logic  fetch_valid;

  int errors = 0;
  int checks = 0;

  if_fetch_unit_if imem ();

  assign imem.rdata = 16'h1000 + imem.addr;
  assign imem.ready = mem_ready;

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hazard         (hazard),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .instruction    (instruction),
    .PC_out         (PC_out),
    .fetch_valid    (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare IF/ID outputs and the request bus; address is only meaningful while requesting.
  task automatic expect_cycle(input string tag, input logic [15:0] e_instr,
                              input logic [15:0] e_pcout, input logic e_fv,
                              input logic e_req, input logic [15:0] e_addr);
    check({tag, ".instr"}, instruction, e_instr);
    check({tag, ".pc_out"}, PC_out, e_pcout);
    check({tag, ".valid"}, {15'd0, fetch_valid}, {15'd0, e_fv});
    check({tag, ".req"}, {15'd0, imem.req}, {15'd0, e_req});
    if (e_req) check({tag, ".addr"}, imem.addr, e_addr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    hazard         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    mem_ready      = 1'b1;

    // Reset
    step();
    step();
    expect_cycle("reset", 16'hF000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;
    #1;
    check("post_reset.req", {15'd0, imem.req}, 16'h0001);
    check("post_reset.addr", imem.addr, 16'h0000);

    // Zero-wait streaming
    step(); expect_cycle("seq0", 16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0001);
    step(); expect_cycle("seq1", 16'h1001, 16'h0002, 1'b1, 1'b1, 16'h0002);
    step(); expect_cycle("seq2", 16'h1002, 16'h0003, 1'b1, 1'b1, 16'h0003);
    step(); expect_cycle("seq3", 16'h1003, 16'h0004, 1'b1, 1'b1, 16'h0004);

    // Memory wait states at address 4
    mem_ready = 1'b0;
    step(); expect_cycle("wait0", 16'hF000, 16'h0004, 1'b0, 1'b1, 16'h0004);
    step(); expect_cycle("wait1", 16'hF000, 16'h0004, 1'b0, 1'b1, 16'h0004);
    step(); expect_cycle("wait2", 16'hF000, 16'h0004, 1'b0, 1'b1, 16'h0004);
    mem_ready = 1'b1;
    step(); expect_cycle("wait_done", 16'h1004, 16'h0005, 1'b1, 1'b1, 16'h0005);
    step(); expect_cycle("seq5", 16'h1005, 16'h0006, 1'b1, 1'b1, 16'h0006);

    // Hazard on completion of address 6
    hazard = 1'b1;
    step(); expect_cycle("hold0", 16'h1005, 16'h0006, 1'b1, 1'b0, 16'h0000);
    step(); expect_cycle("hold1", 16'h1005, 16'h0006, 1'b1, 1'b0, 16'h0000);
    hazard = 1'b0;
    step(); expect_cycle("unhold", 16'h1006, 16'h0007, 1'b1, 1'b1, 16'h0007);
    step(); expect_cycle("seq7", 16'h1007, 16'h0008, 1'b1, 1'b1, 16'h0008);
    step(); expect_cycle("seq8", 16'h1008, 16'h0009, 1'b1, 1'b1, 16'h0009);

    // Redirect while address 9 is pending
    mem_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step(); expect_cycle("drain0", 16'hF000, 16'h0009, 1'b0, 1'b1, 16'h0009);
    redirect_valid = 1'b0;
    step(); expect_cycle("drain1", 16'hF000, 16'h0009, 1'b0, 1'b1, 16'h0009);
    mem_ready = 1'b1;
    step(); expect_cycle("drain_done", 16'hF000, 16'h0009, 1'b0, 1'b1, 16'h0040);
    step(); expect_cycle("tgt0", 16'h1040, 16'h0041, 1'b1, 1'b1, 16'h0041);

    // Redirect together with hazard while holding a buffered word
    hazard = 1'b1;
    step(); expect_cycle("hold_r", 16'h1040, 16'h0041, 1'b1, 1'b0, 16'h0000);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    step(); expect_cycle("hold_flush", 16'hF000, 16'h0041, 1'b0, 1'b1, 16'h0080);
    redirect_valid = 1'b0;
    hazard         = 1'b0;
    step(); expect_cycle("tgt1", 16'h1080, 16'h0081, 1'b1, 1'b1, 16'h0081);

    // Redirect on a completion cycle, target at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    step(); expect_cycle("redir_ffff", 16'hF000, 16'h0081, 1'b0, 1'b1, 16'hFFFF);
    redirect_valid = 1'b0;
    step(); expect_cycle("wrap", 16'h0FFF, 16'h0000, 1'b1, 1'b1, 16'h0000);
    step(); expect_cycle("after_wrap", 16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0001);

    // Reset in the middle of a pending request
    mem_ready = 1'b0;
    step(); expect_cycle("pend", 16'hF000, 16'h0001, 1'b0, 1'b1, 16'h0001);
    rst_n = 1'b0;
    step(); expect_cycle("mid_reset", 16'hF000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    step(); expect_cycle("restart", 16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
